// File: rtl/spi_slave_cfg_pkg.sv
// Shared types and constants for the SPI slave configuration controller:
// FSM states, boot-table type/contents and the round-robin pick helper.
package spi_slave_cfg_pkg;

  localparam int unsigned reg_din_width_c = 8;
  localparam int unsigned boot_len_c      = 4;
  localparam int unsigned ack_timeout_c   = 16;

  typedef enum logic [1:0] {
    StBootIssue,
    StBootWait,
    StIdle,
    StRunWait
  } cfg_state_e;

  typedef logic [reg_din_width_c-1:0] boot_table_t [boot_len_c];

  localparam boot_table_t boot_table_c = '{8'hC3, 8'h1F, 8'h80, 8'h07};

  // One-hot winner of a 2-way request; i_ptr selects the favoured requester on a tie.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic ptr);
    logic [1:0] w_pick;
    w_pick = req;
    if (req == 2'b11) begin
      w_pick = ptr ? 2'b10 : 2'b01;
    end
    return w_pick;
  endfunction

endpackage

// File: rtl/spi_slave_cfg_rr_arb.sv
// Two-way round-robin arbiter: combinational grant, pointer moves to the
// loser whenever a grant is taken.
module spi_slave_cfg_rr_arb
  import spi_slave_cfg_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_grant_en,
  output logic [1:0] o_grant
);

  logic r_ptr;

  assign o_grant = rr_pick(i_req, r_ptr);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= 1'b0;
    end else if (i_grant_en && (|o_grant)) begin
      // Granting requester 0 favours requester 1 next, and vice versa.
      r_ptr <= o_grant[0];
    end
  end

endmodule

// File: rtl/spi_slave_cfg_ctrl.sv
// Register-port controller: issues the boot table after reset, then arbitrates
// runtime writes from two requesters, with busy gating and an ack timeout.
module spi_slave_cfg_ctrl
  import spi_slave_cfg_pkg::*;
#(
  parameter int unsigned reg_din_width_g = reg_din_width_c,
  parameter int unsigned boot_len_g      = boot_len_c,
  parameter int unsigned ack_timeout_g   = ack_timeout_c
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_spi_busy,
  input  logic [1:0]                   i_req_valid,
  input  logic [2*reg_din_width_g-1:0] i_req_din,
  output logic [1:0]                   o_req_done,
  output logic                         o_req_err,
  output logic [reg_din_width_g-1:0]   o_reg_din,
  output logic                         o_reg_din_val,
  input  logic                         i_reg_ack,
  output logic                         o_boot_done,
  output logic                         o_ack_err
);

  localparam int unsigned CntW = $clog2(ack_timeout_g + 1);
  localparam int unsigned IdxW = (boot_len_g > 1) ? $clog2(boot_len_g) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(ack_timeout_g - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(boot_len_g - 1);

  cfg_state_e                 r_state, w_state_nxt;
  logic [IdxW-1:0]            r_idx, w_idx_nxt;
  logic [CntW-1:0]            r_cnt, w_cnt_nxt;
  logic [1:0]                 r_gnt, w_gnt_nxt;
  logic [reg_din_width_g-1:0] r_din, w_din_nxt;
  logic                       r_val, w_val_nxt;
  logic [1:0]                 r_done, w_done_nxt;
  logic                       r_req_err, w_req_err_nxt;
  logic                       r_ack_err, w_ack_err_nxt;
  logic                       r_boot_done, w_boot_done_nxt;

  logic       w_grant_en;
  logic [1:0] w_grant;
  logic       w_ack_hit;
  logic       w_expire;

  assign w_grant_en = (r_state == StIdle) && r_boot_done && !i_spi_busy && (|i_req_valid);

  spi_slave_cfg_rr_arb u_rr_arb (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_req      (i_req_valid),
    .i_grant_en (w_grant_en),
    .o_grant    (w_grant)
  );

  // An ack in the last counted cycle takes priority over the timeout.
  assign w_ack_hit = r_val && i_reg_ack;
  assign w_expire  = r_val && !i_reg_ack && (r_cnt == CntLast);

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_cnt_nxt       = r_cnt;
    w_gnt_nxt       = r_gnt;
    w_din_nxt       = r_din;
    w_val_nxt       = r_val;
    w_done_nxt      = 2'b00;
    w_req_err_nxt   = 1'b0;
    w_ack_err_nxt   = 1'b0;
    w_boot_done_nxt = r_boot_done;

    unique case (r_state)
      StBootIssue: begin
        if (!i_spi_busy) begin
          w_din_nxt   = boot_table_c[r_idx];
          w_val_nxt   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = StBootWait;
        end
      end
      StBootWait: begin
        if (w_ack_hit || w_expire) begin
          w_val_nxt     = 1'b0;
          w_ack_err_nxt = w_expire;
          if (r_idx == IdxLast) begin
            w_boot_done_nxt = 1'b1;
            w_state_nxt     = StIdle;
          end else begin
            w_idx_nxt   = r_idx + 1'b1;
            w_state_nxt = StBootIssue;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      StIdle: begin
        if (w_grant_en) begin
          w_din_nxt   = w_grant[1] ? i_req_din[2*reg_din_width_g-1:reg_din_width_g]
                                   : i_req_din[reg_din_width_g-1:0];
          w_val_nxt   = 1'b1;
          w_cnt_nxt   = '0;
          w_gnt_nxt   = w_grant;
          w_state_nxt = StRunWait;
        end
      end
      StRunWait: begin
        if (w_ack_hit || w_expire) begin
          w_val_nxt     = 1'b0;
          w_done_nxt    = r_gnt;
          w_req_err_nxt = w_expire;
          w_ack_err_nxt = w_expire;
          w_state_nxt   = StIdle;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = StBootIssue;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StBootIssue;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_gnt       <= 2'b00;
      r_din       <= '0;
      r_val       <= 1'b0;
      r_done      <= 2'b00;
      r_req_err   <= 1'b0;
      r_ack_err   <= 1'b0;
      r_boot_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_gnt       <= w_gnt_nxt;
      r_din       <= w_din_nxt;
      r_val       <= w_val_nxt;
      r_done      <= w_done_nxt;
      r_req_err   <= w_req_err_nxt;
      r_ack_err   <= w_ack_err_nxt;
      r_boot_done <= w_boot_done_nxt;
    end
  end

  assign o_reg_din     = r_din;
  assign o_reg_din_val = r_val;
  assign o_req_done    = r_done;
  assign o_req_err     = r_req_err;
  assign o_ack_err     = r_ack_err;
  assign o_boot_done   = r_boot_done;

endmodule
